// File: rtl/pid_pkg.sv
// Shared constants for the PID controller datapath and its PWM back end.
// The PWM period is the full-scale count of the data width minus one.
package pid_pkg;

  localparam int PID_DATA_W       = 8;
  localparam int PWM_PRESCALE_DEF = 4;

  function automatic int pwm_pmax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pid_tick_divider.sv
// Prescaler for the PWM counter: one tick every PRESCALE enabled clocks.
// The count is held at zero while disabled so a new run starts phase-aligned.
module pid_tick_divider #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre_cnt;
  logic          w_tick;

  assign w_tick = en && (r_pre_cnt == LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_pre_cnt <= '0;
    else if (!en)    r_pre_cnt <= '0;
    else if (w_tick) r_pre_cnt <= '0;
    else             r_pre_cnt <= r_pre_cnt + 1'b1;
  end

endmodule

// File: rtl/pid_pwm_generator.sv
// PWM back end for the PID loop: double-buffered duty, applied only at the
// period wrap, with a one-clock period_start strobe usable as a sample trigger.
module pid_pwm_generator
  import pid_pkg::*;
#(
  parameter int WIDTH    = PID_DATA_W,
  parameter int PRESCALE = PWM_PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active,
  output logic             update_pending
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(pwm_pmax(WIDTH) - 1);

  logic             w_tick;
  logic             w_wrap;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty_active;
  logic [WIDTH-1:0] r_duty_pend;
  logic             r_pending;
  logic             r_pwm;
  logic             r_period_start;

  pid_tick_divider #(
    .PRESCALE (PRESCALE)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (w_tick)
  );

  assign w_wrap = w_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)      r_cnt <= '0;
    else if (!en)    r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else if (w_tick) r_cnt <= r_cnt + 1'b1;
  end

  // cnt never reaches PMAX, so duty=PMAX yields a constant-high output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= en && (r_cnt < r_duty_active);
      r_period_start <= w_wrap;
    end
  end

  // While running, a write coinciding with the wrap promotes the old pending
  // value and keeps the new one queued for the following wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty_active <= '0;
      r_duty_pend   <= '0;
      r_pending     <= 1'b0;
    end else if (!en) begin
      if (duty_valid) begin
        r_duty_active <= duty_in;
        r_duty_pend   <= duty_in;
      end else if (r_pending) begin
        r_duty_active <= r_duty_pend;
      end
      r_pending <= 1'b0;
    end else begin
      if (w_wrap && r_pending) r_duty_active <= r_duty_pend;
      if (duty_valid) begin
        r_duty_pend <= duty_in;
        r_pending   <= 1'b1;
      end else if (w_wrap) begin
        r_pending   <= 1'b0;
      end
    end
  end

  assign pwm_out        = r_pwm;
  assign period_start   = r_period_start;
  assign duty_active    = r_duty_active;
  assign update_pending = r_pending;

endmodule

// File: tb/tb_pid_pwm_generator.sv
// Directed bench for pid_pwm_generator: two instances (PRESCALE 1 and 4), a
// time-based reference model compared every cycle, plus hand-computed checks.
module tb_pid_pwm_generator;

  localparam int PMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en  [2];
  logic       dv  [2];
  logic [7:0] din [2];
  logic       pwm [2];
  logic       ps  [2];
  logic       up  [2];
  logic [7:0] da  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pid_pwm_generator #(.WIDTH(8), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .duty_in(din[0]), .duty_valid(dv[0]),
    .pwm_out(pwm[0]), .period_start(ps[0]), .duty_active(da[0]), .update_pending(up[0])
  );

  pid_pwm_generator #(.WIDTH(8), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .duty_in(din[1]), .duty_valid(dv[1]),
    .pwm_out(pwm[1]), .period_start(ps[1]), .duty_active(da[1]), .update_pending(up[1])
  );

  function automatic int psc(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the period follows from the number of
  // enabled clocks since the run started (m_n), not from a counter chain.
  int m_n   [2];
  int m_act [2];
  int m_pend[2];
  bit m_pnd [2];
  bit m_pwm [2];
  bit m_ps  [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_n[d] = 0; m_act[d] = 0; m_pend[d] = 0; m_pnd[d] = 0;
        m_pwm[d] = 0; m_ps[d] = 0;
      end else if (!en[d]) begin
        m_n[d] = 0; m_pwm[d] = 0; m_ps[d] = 0;
        if (dv[d]) begin
          m_act[d] = din[d]; m_pend[d] = din[d];
        end else if (m_pnd[d]) begin
          m_act[d] = m_pend[d];
        end
        m_pnd[d] = 0;
      end else begin
        m_pwm[d] = ((m_n[d] / psc(d)) % PMAX) < m_act[d];
        m_ps[d]  = ((m_n[d] + 1) % (PMAX * psc(d))) == 0;
        if (m_ps[d] && m_pnd[d]) m_act[d] = m_pend[d];
        if (dv[d]) begin
          m_pend[d] = din[d]; m_pnd[d] = 1;
        end else if (m_ps[d]) begin
          m_pnd[d] = 0;
        end
        m_n[d]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("model_pwm%0d", d), pwm[d], m_pwm[d]);
        check($sformatf("model_ps%0d", d),  ps[d],  m_ps[d]);
        check($sformatf("model_duty%0d", d), da[d], m_act[d]);
        check($sformatf("model_pend%0d", d), up[d], m_pnd[d]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Load a duty while disabled, then enable; returns just after the first
  // enabled clock edge so measure() counts from that period's first cycle.
  task automatic start(input int d, input logic [7:0] v);
    cyc();
    en[d] = 1'b0; dv[d] = 1'b1; din[d] = v;
    cyc();
    dv[d] = 1'b0; en[d] = 1'b1;
    cyc();
  endtask

  // Clocks up to and including the next period_start, and high clocks among them.
  task automatic measure(input int d, output int k, output int h);
    bit done;
    k = 0; h = 0; done = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
      if (pwm[d] === 1'b1) h++;
      if (ps[d] === 1'b1) done = 1;
    end
    if (!done) check("period_start_timeout", 0, 1);
  endtask

  int k, h;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; dv[d] = 1'b0; din[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_pwm",  pwm[d], 0);
      check("reset_ps",   ps[d],  0);
      check("reset_duty", da[d],  0);
      check("reset_pend", up[d],  0);
    end
    cyc();
    rst_n = 1'b1;

    // duty 64 at one clock per tick
    start(0, 8'd64);
    measure(0, k, h);
    check("first_ps_delay", k, 255);
    check("d64_high_p1", h, 64);
    measure(0, k, h);
    check("d64_period", k, 255);
    check("d64_high_p2", h, 64);

    // extremes
    start(0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      measure(0, k, h);
      check("d0_period", k, 255);
      check("d0_high", h, 0);
    end
    start(0, 8'd255);
    for (int i = 0; i < 2; i++) begin
      measure(0, k, h);
      check("d255_period", k, 255);
      check("d255_high", h, 255);
    end

    // double buffering
    start(0, 8'd100);
    measure(0, k, h);
    check("d100_high", h, 100);
    repeat (50) cyc();
    dv[0] = 1'b1; din[0] = 8'd200;
    cyc();
    dv[0] = 1'b0;
    @(negedge clk);
    check("dbuf_pending", up[0], 1);
    check("dbuf_active_held", da[0], 100);
    measure(0, k, h);
    check("dbuf_applied", da[0], 200);
    check("dbuf_cleared", up[0], 0);
    measure(0, k, h);
    check("d200_period", k, 255);
    check("d200_high", h, 200);

    // overwrite: last write in the period wins
    repeat (20) cyc();
    dv[0] = 1'b1; din[0] = 8'd10;
    cyc();
    dv[0] = 1'b0;
    repeat (5) cyc();
    dv[0] = 1'b1; din[0] = 8'd20;
    cyc();
    dv[0] = 1'b0;
    measure(0, k, h);
    check("ovw_applied", da[0], 20);
    check("ovw_cleared", up[0], 0);

    // write on the exact wrap cycle while 20 is pending
    repeat (10) cyc();
    dv[0] = 1'b1; din[0] = 8'd20;
    cyc();
    dv[0] = 1'b0;
    repeat (243) cyc();
    dv[0] = 1'b1; din[0] = 8'd30;
    cyc();
    dv[0] = 1'b0;
    @(negedge clk);
    check("coll_ps", ps[0], 1);
    check("coll_active", da[0], 20);
    check("coll_pending", up[0], 1);
    measure(0, k, h);
    check("coll_high", h, 20);
    check("coll_next_applied", da[0], 30);
    check("coll_next_cleared", up[0], 0);
    en[0] = 1'b0;

    // prescaler 4
    start(1, 8'd3);
    for (int i = 0; i < 2; i++) begin
      measure(1, k, h);
      check("ps4_period", k, 1020);
      check("ps4_high", h, 12);
    end

    // reset mid-period with a pending update
    repeat (100) cyc();
    dv[1] = 1'b1; din[1] = 8'd50;
    cyc();
    dv[1] = 1'b0;
    repeat (20) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm",  pwm[1], 0);
    check("rst_mid_ps",   ps[1],  0);
    check("rst_mid_duty", da[1],  0);
    check("rst_mid_pend", up[1],  0);
    measure(1, k, h);
    check("post_rst_period", k, 1020);
    check("post_rst_high", h, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pid_pwm_generator.md
Name: pid_pwm_generator

Overview:
- Downstream stage of the PID controller: consumes the 8-bit unsigned control value and converts it to a single-bit PWM drive for the actuator pin.
- Duty updates are double-buffered and take effect only at a period boundary, so no glitched or truncated periods occur.
- A one-cycle `period_start` strobe marks each period boundary; it is available as a sample trigger for the PID loop.
- Programmable clock prescaler sets the PWM frequency.

Parameters:
- WIDTH, 8: duty and counter width in bits. The period is PMAX = 2^WIDTH-1 ticks (255 by default).
- PRESCALE, 4: system clocks per PWM tick. Legal range is >= 1; 1 means one tick every clock.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- en  in  1  run enable. When low, the counter is held idle and the output is low.
- duty_in  in  WIDTH  new duty value; unsigned; the PID control_signal.
- duty_valid  in  1  qualifies duty_in for one cycle. No backpressure; always accepted.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  one-clock pulse on each counter wrap.
- duty_active  out  WIDTH  duty value currently applied.
- update_pending  out  1  high while a buffered duty value awaits the next wrap.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pre_cnt=0, cnt=0, duty_active=0, duty_pend=0.
  - update_pending=0, pwm_out=0, period_start=0.
  - Reset wins over every other input. Reset mid-period aborts the period immediately; a pending update is discarded.
- Tick: `tick` is asserted when en=1 and pre_cnt==PRESCALE-1.
  - pre_cnt increments while en=1 and wraps to 0 on tick.
  - For PRESCALE=1, tick is asserted on every enabled cycle.
- Counter: cnt runs 0..PMAX-1.
  - On tick, cnt increments.
  - On tick with cnt==PMAX-1, cnt wraps to 0; this is the wrap event.
- Output: pwm_out <= en && (cnt < duty_active).
  - Registered, so pwm_out lags cnt/duty_active by 1 clk.
  - duty=0 gives constant low; duty=PMAX gives constant high.
  - High time is duty×PRESCALE clks per period of PMAX×PRESCALE clks.
- period_start <= wrap event (1 clk wide, registered).
- Duty capture while en=1:
  - duty_valid loads duty_pend and sets update_pending=1.
  - A later duty_valid before the wrap overwrites duty_pend; last value wins.
- Wrap apply: on the wrap event with update_pending=1, duty_active<=duty_pend and update_pending<=0.
- duty_valid in the same cycle as a wrap:
  - The old duty_pend is applied to duty_active.
  - The new value is captured into duty_pend.
  - update_pending stays 1; the new value applies at the following wrap.
- Disabled (en=0):
  - pre_cnt=0, cnt=0, pwm_out=0, period_start=0.
  - duty_valid loads duty_pend and duty_active directly; update_pending=0.
  - Any pending value present when en falls is applied to duty_active on that first disabled cycle.
- Enable rise: counting starts with cnt=0, pre_cnt=0 on the first en=1 cycle. There is no period_start at start; the first pulse comes at the first wrap.
- Arithmetic: all values are unsigned. There is no saturation logic, since cnt is bounded by the wrap compare.

Decomposition:
- Shared package `pid_pkg`:
  - PID_DATA_W=8.
  - PWM_PMAX function/constant (2^W-1).
  - PRESCALE default constant.
- One sub-module, `pid_tick_divider`:
  - Inputs: clk, rst_n, en. Output: tick.
  - Contains the PRESCALE counter, clear when en=0.
- The counter, buffering and compare logic stay in the top module.

Test Plan:
- Duty cycle: PRESCALE=1, duty_valid with 64 while en=0, then en=1 → pwm_out high for exactly 64 clks, then low for 191 clks; period 255 clks. First period_start appears 255 clks after en rises.
- Extremes: duty 0 → pwm_out never high over 3 periods. Duty 255 → pwm_out constantly high once enabled. period_start pulses every 255 clks in both cases.
- Double buffering: running at duty 100, duty_valid=200 mid-period → update_pending=1 and duty_active stays 100 until the wrap. The next period is high for 200 clks.
- Overwrite and wrap collision:
  - Two writes 10 then 20 in one period → 20 is applied at the wrap.
  - duty_valid=30 on the exact wrap cycle with 20 pending → duty_active=20 and update_pending remains 1. 30 is applied at the next wrap.
- Prescaler: PRESCALE=4, duty 3 → pwm_out high 12 clks per 1020-clk period. period_start spacing is 1020.
- Reset mid-period with a pending update → all outputs 0 on the next clk. After release with en=1, pwm_out stays low because duty_active=0.
